// File: rtl/ray_point_pipe.sv
// Two-stage ray-point evaluator: point = dir * p + ori per axis, with valid/ready flow control,
// tag passthrough, miss flagging and a saturating miss counter. Define RAY_POINT_SAT_EN to clamp sums.

module ray_point_axis #(
   parameter int DIR_W     = 10,
   parameter int ORI_W     = 10,
   parameter int P_RANGE_W = 10,
   parameter int OUT_W     = 18
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 i_ld_s1,
   input  logic                 i_ld_s2,
   input  logic                 i_miss_s1,
   input  logic [DIR_W-1:0]     i_dir,
   input  logic [ORI_W-1:0]     i_ori,
   input  logic [P_RANGE_W-1:0] i_p_lo,
   output logic [OUT_W-1:0]     o_out
);
   localparam int PROD_W = DIR_W + P_RANGE_W;
   localparam int SUM_W  = ((PROD_W > ORI_W) ? PROD_W : ORI_W) + 1;
   localparam int EXT_W  = (SUM_W > OUT_W) ? SUM_W : OUT_W;

   logic [PROD_W-1:0] r_prod;
   logic [ORI_W-1:0]  r_ori;
   logic [OUT_W-1:0]  r_out;
   logic [EXT_W-1:0]  w_sum;
   logic [OUT_W-1:0]  w_red;

   always_comb begin
      w_sum = EXT_W'(r_prod) + EXT_W'(r_ori);
`ifdef RAY_POINT_SAT_EN
      w_red = ((w_sum >> OUT_W) != '0) ? '1 : w_sum[OUT_W-1:0];
`else
      w_red = OUT_W'(w_sum);
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_prod <= '0;
         r_ori  <= '0;
         r_out  <= '0;
      end else begin
         if (i_ld_s1) begin
            r_prod <= PROD_W'(i_dir) * PROD_W'(i_p_lo);
            r_ori  <= i_ori;
         end
         // a miss forces every axis to all ones so no coordinate is left stale
         if (i_ld_s2)
            r_out <= i_miss_s1 ? '1 : w_red;
      end
   end

   assign o_out = r_out;
endmodule

module ray_point_pipe #(
   parameter int P_W       = 19,
   parameter int P_RANGE_W = 10,
   parameter int ORI_W     = 10,
   parameter int DIR_W     = 10,
   parameter int OUT_W     = 18,
   parameter int TAG_W     = 8,
   parameter int CNT_W     = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [P_W-1:0]       in_p,
   input  logic [TAG_W-1:0]     in_tag,
   input  logic [ORI_W-1:0]     ori_x,
   input  logic [ORI_W-1:0]     ori_y,
   input  logic [ORI_W-1:0]     ori_z,
   input  logic [DIR_W-1:0]     dir_x,
   input  logic [DIR_W-1:0]     dir_y,
   input  logic [DIR_W-1:0]     dir_z,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [OUT_W-1:0]     out_x,
   output logic [OUT_W-1:0]     out_y,
   output logic [OUT_W-1:0]     out_z,
   output logic [P_RANGE_W-1:0] out_p,
   output logic                 out_miss,
   output logic [TAG_W-1:0]     out_tag,
   output logic [CNT_W-1:0]     miss_cnt
);
   logic [1:0]                 r_vld_pipe;
   logic                       r_miss_s1, r_miss_s2;
   logic [P_RANGE_W-1:0]       r_p_s1, r_p_s2;
   logic [TAG_W-1:0]           r_tag_s1, r_tag_s2;
   logic [CNT_W-1:0]           r_cnt;
   logic                       w_adv, w_acc, w_ld_s2, w_miss_in;
   logic [2:0][DIR_W-1:0]      w_dir;
   logic [2:0][ORI_W-1:0]      w_ori;
   logic [2:0][OUT_W-1:0]      w_out;

   // single global stall: the whole pipe moves only when the output slot is free or draining
   assign w_adv     = !r_vld_pipe[1] || out_ready;
   assign w_acc     = in_valid && w_adv;
   assign w_ld_s2   = w_adv && r_vld_pipe[0];
   assign w_miss_in = |in_p[P_W-1:P_RANGE_W];
   assign w_dir     = {dir_z, dir_y, dir_x};
   assign w_ori     = {ori_z, ori_y, ori_x};

   for (genvar a = 0; a < 3; a++) begin : g_axis
      ray_point_axis #(
         .DIR_W(DIR_W), .ORI_W(ORI_W), .P_RANGE_W(P_RANGE_W), .OUT_W(OUT_W)
      ) u_axis (
         .clk      (clk),
         .rst_n    (rst_n),
         .i_ld_s1  (w_acc),
         .i_ld_s2  (w_ld_s2),
         .i_miss_s1(r_miss_s1),
         .i_dir    (w_dir[a]),
         .i_ori    (w_ori[a]),
         .i_p_lo   (in_p[P_RANGE_W-1:0]),
         .o_out    (w_out[a])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vld_pipe <= '0;
         r_miss_s1  <= 1'b0;
         r_p_s1     <= '0;
         r_tag_s1   <= '0;
         r_miss_s2  <= 1'b0;
         r_p_s2     <= '0;
         r_tag_s2   <= '0;
      end else if (w_adv) begin
         r_vld_pipe <= {r_vld_pipe[0], in_valid};
         if (in_valid) begin
            r_miss_s1 <= w_miss_in;
            r_p_s1    <= in_p[P_RANGE_W-1:0];
            r_tag_s1  <= in_tag;
         end
         if (r_vld_pipe[0]) begin
            r_miss_s2 <= r_miss_s1;
            r_p_s2    <= r_miss_s1 ? '1 : r_p_s1;
            r_tag_s2  <= r_tag_s1;
         end
      end
   end

   // counted at acceptance so stalled or flushed misses are still included
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_cnt <= '0;
      else if (w_acc && w_miss_in && (r_cnt != '1))
         r_cnt <= r_cnt + CNT_W'(1);
   end

   assign in_ready  = w_adv;
   assign out_valid = r_vld_pipe[1];
   assign out_x     = w_out[0];
   assign out_y     = w_out[1];
   assign out_z     = w_out[2];
   assign out_p     = r_p_s2;
   assign out_miss  = r_miss_s2;
   assign out_tag   = r_tag_s2;
   assign miss_cnt  = r_cnt;
endmodule

// File: tb/tb_ray_point_pipe.sv
// Directed self-checking bench for ray_point_pipe; a second instance with CNT_W=2 checks counter saturation.

module tb_ray_point_pipe;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, out_ready;
   logic [18:0] in_p;
   logic [7:0]  in_tag;
   logic [9:0]  ori_x, ori_y, ori_z, dir_x, dir_y, dir_z;
   logic        in_ready, out_valid, out_miss;
   logic [17:0] out_x, out_y, out_z;
   logic [9:0]  out_p;
   logic [7:0]  out_tag;
   logic [15:0] miss_cnt;
   logic        in_ready2, out_valid2, out_miss2;
   logic [17:0] out_x2, out_y2, out_z2;
   logic [9:0]  out_p2;
   logic [7:0]  out_tag2;
   logic [1:0]  miss_cnt2;
   int          checks = 0;
   int          errors = 0;
   int          lat;

   always #5 clk = ~clk;

   ray_point_pipe dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_p(in_p), .in_tag(in_tag),
      .ori_x(ori_x), .ori_y(ori_y), .ori_z(ori_z), .dir_x(dir_x), .dir_y(dir_y), .dir_z(dir_z),
      .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x), .out_y(out_y), .out_z(out_z),
      .out_p(out_p), .out_miss(out_miss), .out_tag(out_tag), .miss_cnt(miss_cnt));

   ray_point_pipe #(.CNT_W(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2), .in_p(in_p), .in_tag(in_tag),
      .ori_x(ori_x), .ori_y(ori_y), .ori_z(ori_z), .dir_x(dir_x), .dir_y(dir_y), .dir_z(dir_z),
      .out_valid(out_valid2), .out_ready(out_ready), .out_x(out_x2), .out_y(out_y2), .out_z(out_z2),
      .out_p(out_p2), .out_miss(out_miss2), .out_tag(out_tag2), .miss_cnt(miss_cnt2));

   task automatic do_reset;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   // presents one request, scrambles inputs after acceptance, waits (bounded) for its result
   task automatic send_one(input logic [18:0] p, input logic [7:0] tag,
                           input logic [9:0] ox, input logic [9:0] oy, input logic [9:0] oz,
                           input logic [9:0] dx, input logic [9:0] dy, input logic [9:0] dz);
      out_ready = 1'b1;
      in_valid = 1'b1; in_p = p; in_tag = tag;
      ori_x = ox; ori_y = oy; ori_z = oz; dir_x = dx; dir_y = dy; dir_z = dz;
      @(posedge clk); #1;
      in_valid = 1'b0; in_p = 19'($urandom); in_tag = 8'($urandom);
      ori_x = 10'($urandom); dir_x = 10'($urandom); dir_y = 10'($urandom);
      lat = 0;
      while (!out_valid && lat < 6) begin
         @(posedge clk); #1;
         lat++;
      end
      if (!out_valid) begin
         checks++; errors++;
         $display("FAIL timeout tag=%0h: out_valid=%b required 1", tag, out_valid);
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_p = '0; in_tag = '0;
      ori_x = '0; ori_y = '0; ori_z = '0; dir_x = '0; dir_y = '0; dir_z = '0;
      #2;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
      checks++; if ({out_x, out_y, out_z} !== '0) begin errors++; $display("FAIL rst_xyz got %h exp 0", {out_x, out_y, out_z}); end
      checks++; if ({out_p, out_miss, out_tag} !== '0) begin errors++; $display("FAIL rst_p_miss_tag got %h exp 0", {out_p, out_miss, out_tag}); end
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b exp 1", in_ready); end
      checks++; if (miss_cnt !== 16'd0) begin errors++; $display("FAIL rst_miss_cnt got %0d exp 0", miss_cnt); end
      @(posedge clk); #1;
   endtask

   task automatic test_basic;
      send_one(19'd5, 8'hA5, 10'd7, 10'd2, 10'd0, 10'd3, 10'd0, 10'd1);
      checks++; if (lat !== 1) begin errors++; $display("FAIL basic_latency got %0d exp 1", lat); end
      checks++; if (out_x !== 18'd22) begin errors++; $display("FAIL basic_x got %0d exp 22", out_x); end
      checks++; if (out_y !== 18'd2) begin errors++; $display("FAIL basic_y got %0d exp 2", out_y); end
      checks++; if (out_z !== 18'd5) begin errors++; $display("FAIL basic_z got %0d exp 5", out_z); end
      checks++; if (out_p !== 10'd5 || out_miss !== 1'b0) begin errors++; $display("FAIL basic_p_miss got %0d/%b exp 5/0", out_p, out_miss); end
      checks++; if (out_tag !== 8'hA5) begin errors++; $display("FAIL basic_tag got %h exp a5", out_tag); end
   endtask

   task automatic test_range;
      do_reset;
      send_one(19'd1023, 8'h01, 10'd0, 10'd0, 10'd0, 10'd1, 10'd1, 10'd1);
      checks++; if (out_p !== 10'd1023 || out_miss !== 1'b0) begin errors++; $display("FAIL range_1023 got p=%0d miss=%b exp 1023/0", out_p, out_miss); end
      checks++; if (out_x !== 18'd1023) begin errors++; $display("FAIL range_1023_x got %0d exp 1023", out_x); end
      send_one(19'd1024, 8'h02, 10'd5, 10'd5, 10'd5, 10'd1, 10'd1, 10'd1);
      checks++; if (out_miss !== 1'b1 || out_p !== 10'h3FF) begin errors++; $display("FAIL range_1024 got p=%h miss=%b exp 3ff/1", out_p, out_miss); end
      checks++; if ({out_x, out_y, out_z} !== {3{18'h3FFFF}}) begin errors++; $display("FAIL range_1024_xyz got %h/%h/%h exp 3ffff", out_x, out_y, out_z); end
      checks++; if (out_tag !== 8'h02) begin errors++; $display("FAIL range_1024_tag got %h exp 02", out_tag); end
      send_one(19'h7FFFF, 8'h03, 10'd1, 10'd1, 10'd1, 10'd1, 10'd1, 10'd1);
      checks++; if (out_miss !== 1'b1 || out_x !== 18'h3FFFF) begin errors++; $display("FAIL range_neg got miss=%b x=%h exp 1/3ffff", out_miss, out_x); end
      checks++; if (miss_cnt !== 16'd2) begin errors++; $display("FAIL range_miss_cnt got %0d exp 2", miss_cnt); end
      @(posedge clk); #1;
   endtask

   task automatic test_overflow;
      logic [17:0] exp_v;
`ifdef RAY_POINT_SAT_EN
      exp_v = 18'd262143;
`else
      exp_v = 18'd261120;
`endif
      send_one(19'd1023, 8'h44, 10'd1023, 10'd1023, 10'd0, 10'd1023, 10'd1023, 10'd2);
      checks++; if (out_x !== exp_v || out_y !== exp_v) begin errors++; $display("FAIL overflow got %0d/%0d exp %0d", out_x, out_y, exp_v); end
      checks++; if (out_z !== 18'd2046 || out_miss !== 1'b0) begin errors++; $display("FAIL overflow_z got %0d miss=%b exp 2046/0", out_z, out_miss); end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back;
      int sent = 0;
      int got = 0;
      for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
         out_ready = !(cyc >= 4 && cyc < 7);
         if (sent < 6) begin
            in_valid = 1'b1; in_tag = 8'h10 + 8'(sent); in_p = 19'(sent + 1);
            dir_x = 10'd2; ori_x = 10'(sent);
         end else begin
            in_valid = 1'b0; in_p = 19'($urandom); in_tag = 8'($urandom);
         end
         @(negedge clk);
         if (out_valid && !out_ready) begin
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready cyc=%0d got %b exp 0", cyc, in_ready); end
            checks++;
            if (out_tag !== 8'h10 + 8'(got) || out_x !== 18'(3 * got + 2)) begin
               errors++; $display("FAIL stall_hold cyc=%0d got tag=%h x=%0d exp tag=%h x=%0d", cyc, out_tag, out_x, 8'h10 + 8'(got), 3 * got + 2);
            end
         end
         if (out_valid && out_ready) begin
            checks++;
            if (out_tag !== 8'h10 + 8'(got) || out_x !== 18'(3 * got + 2)) begin
               errors++; $display("FAIL stream_out idx=%0d got tag=%h x=%0d exp tag=%h x=%0d", got, out_tag, out_x, 8'h10 + 8'(got), 3 * got + 2);
            end
            got++;
         end
         if (in_valid && in_ready) sent++;
         @(posedge clk); #1;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      checks++; if (got !== 6) begin errors++; $display("FAIL stream_count got %0d exp 6", got); end
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_dup out_valid=%b exp 0", out_valid); end
      @(posedge clk); #1;
   endtask

   task automatic test_miss_sat;
      do_reset;
      for (int i = 0; i < 5; i++) begin
         send_one(19'h40000 | 19'(i), 8'(i), 10'd0, 10'd0, 10'd0, 10'd1, 10'd1, 10'd1);
         if (i == 2) begin
            checks++; if (miss_cnt2 !== 2'd3) begin errors++; $display("FAIL sat_at3 got %0d exp 3", miss_cnt2); end
         end
      end
      checks++; if (miss_cnt2 !== 2'd3) begin errors++; $display("FAIL sat_hold got %0d exp 3", miss_cnt2); end
      checks++; if (miss_cnt !== 16'd5) begin errors++; $display("FAIL sat_wide got %0d exp 5", miss_cnt); end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid;
      do_reset;
      out_ready = 1'b0;
      in_valid = 1'b1; in_p = 19'd2048; in_tag = 8'h77; dir_x = 10'd1; ori_x = 10'd1;
      @(posedge clk); #1;
      in_p = 19'd9; in_tag = 8'h78;
      @(posedge clk); #1;
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1 || out_tag !== 8'h77) begin errors++; $display("FAIL mid_pre got v=%b tag=%h exp 1/77", out_valid, out_tag); end
      checks++; if (miss_cnt !== 16'd1) begin errors++; $display("FAIL mid_cnt got %0d exp 1", miss_cnt); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0 || miss_cnt !== 16'd0) begin errors++; $display("FAIL mid_rst got v=%b cnt=%0d exp 0/0", out_valid, miss_cnt); end
      checks++; if ({out_x, out_y, out_z, out_p, out_miss, out_tag} !== '0) begin errors++; $display("FAIL mid_rst_out got %h exp 0", {out_x, out_y, out_z, out_p, out_miss, out_tag}); end
      @(posedge clk); #1 rst_n = 1'b1; out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_flush cyc=%0d got %b exp 0", i, out_valid); end
      end
   endtask

   initial begin
      test_reset;
      test_basic;
      test_range;
      test_overflow;
      test_back_to_back;
      test_miss_sat;
      test_reset_mid;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
